// File: rtl/pipeline_stage_reg.sv
// pipeline_stage_reg: valid/ready pipeline register stage with flush.
// Optional skid buffer (FULL state, registered o_ready) enabled by defining
// macro PIPELINE_SKID_BUF_EN; default build is a single-entry stage with a
// combinational o_ready.
module pipeline_stage_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_flush,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data,
    output logic [1:0]        o_count
);

`ifdef PIPELINE_SKID_BUF_EN
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;
`else
    typedef enum logic {
        EMPTY = 1'b0,
        BUSY  = 1'b1
    } state_t;
`endif

    state_t            state, state_nxt;
    logic [CTRL_W-1:0] main_ctrl, main_ctrl_nxt;
    logic [DATA_W-1:0] main_data, main_data_nxt;
    logic              in_xfer, out_xfer;

`ifdef PIPELINE_SKID_BUF_EN
    logic [CTRL_W-1:0] skid_ctrl, skid_ctrl_nxt;
    logic [DATA_W-1:0] skid_data, skid_data_nxt;
    logic              ready_q;

    // ready_q is purely registered; i_rst only gates it so reset forces 0.
    assign o_ready = ready_q & ~i_rst;
`else
    assign o_ready = ~i_rst & (~o_valid | i_ready);
`endif

    assign in_xfer  = i_valid & o_ready;
    assign out_xfer = o_valid & i_ready;
    assign o_valid  = (state != EMPTY);
    // Main register may keep stale contents after a flush; ctrl is masked instead.
    assign o_ctrl   = o_valid ? main_ctrl : '0;
    assign o_data   = main_data;

    // Occupancy reported directly from the state.
    always_comb begin
        o_count = 2'd0;
        case (state)
            BUSY:    o_count = 2'd1;
`ifdef PIPELINE_SKID_BUF_EN
            FULL:    o_count = 2'd2;
`endif
            default: o_count = 2'd0;
        endcase
    end

    // Next-state and register-load selection from the two handshakes.
    always_comb begin
        state_nxt     = state;
        main_ctrl_nxt = main_ctrl;
        main_data_nxt = main_data;
`ifdef PIPELINE_SKID_BUF_EN
        skid_ctrl_nxt = skid_ctrl;
        skid_data_nxt = skid_data;
`endif
        case (state)
            EMPTY: begin
                if (in_xfer) begin
                    state_nxt     = BUSY;
                    main_ctrl_nxt = i_ctrl;
                    main_data_nxt = i_data;
                end
            end
            BUSY: begin
`ifdef PIPELINE_SKID_BUF_EN
                if (in_xfer && !out_xfer) begin
                    state_nxt     = FULL;
                    skid_ctrl_nxt = i_ctrl;
                    skid_data_nxt = i_data;
                end else if (in_xfer && out_xfer) begin
`else
                if (in_xfer) begin
`endif
                    main_ctrl_nxt = i_ctrl;
                    main_data_nxt = i_data;
                end else if (out_xfer) begin
                    state_nxt = EMPTY;
                end
            end
`ifdef PIPELINE_SKID_BUF_EN
            FULL: begin
                if (out_xfer) begin
                    state_nxt     = BUSY;
                    main_ctrl_nxt = skid_ctrl;
                    main_data_nxt = skid_data;
                end
            end
`endif
            default: state_nxt = EMPTY;
        endcase
    end

    // State and payload registers; reset beats flush, flush beats transfers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= EMPTY;
            main_ctrl <= '0;
            main_data <= '0;
`ifdef PIPELINE_SKID_BUF_EN
            skid_ctrl <= '0;
            skid_data <= '0;
            ready_q   <= 1'b1;
`endif
        end else if (i_flush) begin
            state     <= EMPTY;
`ifdef PIPELINE_SKID_BUF_EN
            ready_q   <= 1'b1;
`endif
        end else begin
            state     <= state_nxt;
            main_ctrl <= main_ctrl_nxt;
            main_data <= main_data_nxt;
`ifdef PIPELINE_SKID_BUF_EN
            skid_ctrl <= skid_ctrl_nxt;
            skid_data <= skid_data_nxt;
            ready_q   <= (state_nxt != FULL);
`endif
        end
    end

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// Self-checking bench for pipeline_stage_reg (adapts to PIPELINE_SKID_BUF_EN).
module tb_pipeline_stage_reg;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 16;
`ifdef PIPELINE_SKID_BUF_EN
    localparam bit SKID_EN = 1'b1;
    localparam int CAP     = 2;
`else
    localparam bit SKID_EN = 1'b0;
    localparam int CAP     = 1;
`endif

    logic              clk = 1'b0;
    logic              i_rst, i_flush, i_valid, i_ready;
    logic              o_ready, o_valid;
    logic [CTRL_W-1:0] i_ctrl, o_ctrl;
    logic [DATA_W-1:0] i_data, o_data;
    logic [1:0]        o_count;

    always #5 clk = ~clk;

    pipeline_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
        .i_clk   (clk),
        .i_rst   (i_rst),
        .i_flush (i_flush),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_ctrl  (i_ctrl),
        .i_data  (i_data),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_ctrl  (o_ctrl),
        .o_data  (o_data),
        .o_count (o_count)
    );

    typedef struct {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
    } pl_t;

    typedef struct {
        logic              rst, flush, valid;
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
        logic              rdy;
        logic              ev;
        logic [CTRL_W-1:0] ectrl;
        logic [DATA_W-1:0] edata;
        logic              chkdata;
        logic [1:0]        ecnt;
        logic              erdy;
    } vec_t;

    pl_t               mq[$];          // payloads the stage should be holding, oldest first
    logic [DATA_W-1:0] delivered[$];   // data observed leaving the stage
    int                n_checks = 0;
    int                n_pass   = 0;
    vec_t              vt[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Can the stage take a payload, given how many it holds and the inputs now.
    function automatic logic model_ready(input logic rst, input logic rdy);
        if (rst) return 1'b0;
        return (mq.size() < CAP) || (!SKID_EN && rdy);
    endfunction

    task automatic drive(input logic rst, input logic flush, input logic valid,
                         input logic [CTRL_W-1:0] ctrl, input logic [DATA_W-1:0] data,
                         input logic rdy, output logic acc);
        logic out_x;
        pl_t  p;
        i_rst = rst; i_flush = flush; i_valid = valid;
        i_ctrl = ctrl; i_data = data; i_ready = rdy;
        acc   = valid && model_ready(rst, rdy);
        out_x = (mq.size() > 0) && rdy;
        if (o_valid === 1'b1 && rdy) delivered.push_back(o_data);
        @(posedge clk);
        if (rst || flush) begin
            mq.delete();
            acc = 1'b0;
        end else begin
            if (out_x) p = mq.pop_front();
            if (acc) begin
                p.ctrl = ctrl;
                p.data = data;
                mq.push_back(p);
            end
        end
        #1;
    endtask

    task automatic check_model(input string tag);
        logic ev;
        ev = (mq.size() > 0);
        chk({tag, "_valid"}, 64'(o_valid), 64'(ev));
        chk({tag, "_ctrl"},  64'(o_ctrl),  ev ? 64'(mq[0].ctrl) : 64'd0);
        chk({tag, "_count"}, 64'(o_count), 64'(mq.size()));
        chk({tag, "_ready"}, 64'(o_ready), 64'(model_ready(i_rst, i_ready)));
        if (ev) chk({tag, "_data"}, 64'(o_data), 64'(mq[0].data));
    endtask

    task automatic do_reset();
        logic a;
        drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, a);
        check_model("rst");
    endtask

    initial begin
        logic acc;
        int   k;

        // Directed vectors: reset, single transfer, drain, stall, flush, reset-with-flush.
        vt[0] = '{1'b1, 1'b0, 1'b0, 16'h0000, 32'h0000_0000, 1'b1, 1'b0, 16'h0000, 32'h0000_0000, 1'b1, 2'd0, 1'b0};
        vt[1] = '{1'b0, 1'b0, 1'b1, 16'h00A5, 32'h1234_5678, 1'b1, 1'b1, 16'h00A5, 32'h1234_5678, 1'b1, 2'd1, 1'b1};
        vt[2] = '{1'b0, 1'b0, 1'b0, 16'h0000, 32'h0000_0000, 1'b1, 1'b0, 16'h0000, 32'h0000_0000, 1'b0, 2'd0, 1'b1};
        vt[3] = '{1'b0, 1'b0, 1'b1, 16'h0001, 32'hAAAA_5555, 1'b0, 1'b1, 16'h0001, 32'hAAAA_5555, 1'b1, 2'd1, SKID_EN};
        vt[4] = '{1'b0, 1'b1, 1'b1, 16'h0007, 32'h0000_0077, 1'b0, 1'b0, 16'h0000, 32'h0000_0000, 1'b0, 2'd0, 1'b1};
        vt[5] = '{1'b0, 1'b0, 1'b1, 16'hBEEF, 32'hCAFE_F00D, 1'b1, 1'b1, 16'hBEEF, 32'hCAFE_F00D, 1'b1, 2'd1, 1'b1};
        vt[6] = '{1'b1, 1'b1, 1'b1, 16'h1111, 32'h0000_2222, 1'b0, 1'b0, 16'h0000, 32'h0000_0000, 1'b1, 2'd0, 1'b0};
        vt[7] = '{1'b0, 1'b0, 1'b0, 16'h0000, 32'h0000_0000, 1'b1, 1'b0, 16'h0000, 32'h0000_0000, 1'b1, 2'd0, 1'b1};

        for (int i = 0; i < 8; i++) begin
            drive(vt[i].rst, vt[i].flush, vt[i].valid, vt[i].ctrl, vt[i].data, vt[i].rdy, acc);
            chk($sformatf("tv%0d_valid", i), 64'(o_valid), 64'(vt[i].ev));
            chk($sformatf("tv%0d_ctrl", i),  64'(o_ctrl),  64'(vt[i].ectrl));
            chk($sformatf("tv%0d_count", i), 64'(o_count), 64'(vt[i].ecnt));
            chk($sformatf("tv%0d_ready", i), 64'(o_ready), 64'(vt[i].erdy));
            if (vt[i].chkdata) chk($sformatf("tv%0d_data", i), 64'(o_data), 64'(vt[i].edata));
        end

        // Back-pressure: offer D0..D2 with downstream stalled, then release.
        do_reset();
        k = 0;
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 1'b0, 1'b1, 16'(k), 32'hD000_0000 + 32'(k), 1'b0, acc);
            check_model("bp_stall");
            if (acc) k++;
        end
        chk("bp_count", 64'(o_count), 64'(CAP));
        chk("bp_ready", 64'(o_ready), 64'd0);
        chk("bp_accepted", 64'(k), 64'(CAP));
        delivered.delete();
        for (int c = 0; c < 12; c++) begin
            drive(1'b0, 1'b0, k < 3, 16'(k), 32'hD000_0000 + 32'(k), 1'b1, acc);
            check_model("bp_drain");
            if (acc) k++;
        end
        chk("bp_delivered_n", 64'(delivered.size()), 64'd3);
        for (int i = 0; i < delivered.size(); i++)
            chk($sformatf("bp_order%0d", i), 64'(delivered[i]), 64'(32'hD000_0000 + 32'(i)));

        // Streaming: 100 back-to-back payloads at full rate.
        do_reset();
        delivered.delete();
        for (int i = 0; i < 100; i++) begin
            drive(1'b0, 1'b0, 1'b1, 16'(i), 32'h5000_0000 + 32'(i), 1'b1, acc);
            check_model("stream");
            chk("stream_count1", 64'(o_count), 64'd1);
        end
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, acc);
        check_model("stream_end");
        chk("stream_delivered_n", 64'(delivered.size()), 64'd100);
        for (int i = 0; i < delivered.size(); i++)
            chk($sformatf("stream_order%0d", i), 64'(delivered[i]), 64'(32'h5000_0000 + 32'(i)));

        // Flush with the stage holding as much as it can, plus a payload offered.
        do_reset();
        for (int c = 0; c < 2; c++) begin
            drive(1'b0, 1'b0, 1'b1, 16'h0E00 + 16'(c), 32'hE000_0000 + 32'(c), 1'b0, acc);
            check_model("fl_fill");
        end
        drive(1'b0, 1'b1, 1'b1, 16'hDEAD, 32'hBAD0_BAD0, 1'b0, acc);
        check_model("fl_flush");
        chk("fl_valid0", 64'(o_valid), 64'd0);
        chk("fl_count0", 64'(o_count), 64'd0);
        delivered.delete();
        for (int c = 0; c < 5; c++) begin
            drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, acc);
            check_model("fl_idle");
        end
        chk("fl_nothing_out", 64'(delivered.size()), 64'd0);

        // Reset (with flush) while busy; no stale payload afterwards.
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 16'h0F0F, 32'h7777_8888, 1'b0, acc);
        check_model("mr_busy");
        drive(1'b1, 1'b1, 1'b1, 16'h3333, 32'h4444_5555, 1'b0, acc);
        check_model("mr_rst");
        chk("mr_data0", 64'(o_data), 64'd0);
        chk("mr_ready0", 64'(o_ready), 64'd0);
        delivered.delete();
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, acc);
        check_model("mr_rel");
        chk("mr_ready1", 64'(o_ready), 64'd1);
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, acc);
            check_model("mr_idle");
        end
        chk("mr_nothing_out", 64'(delivered.size()), 64'd0);

        // Randomized traffic with occasional flush and reset.
        do_reset();
        for (int c = 0; c < 500; c++) begin
            drive(($urandom % 100) == 0, ($urandom % 40) == 0, ($urandom % 10) < 7,
                  16'($urandom), 32'($urandom), ($urandom % 10) < 6, acc);
            check_model("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
